// File: rtl/bus_guard_pkg.sv
// Shared constants and types for the bus_guard block: register offsets,
// STATUS bit positions, FSM state encoding and the debug view of the FSM.
package bus_guard_pkg;

  // Word offsets inside the 16-byte register window (mem_addr[3:2])
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_FADDR  = 2'd1;
  localparam logic [1:0] REG_FCOUNT = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS register bit indices
  localparam int ST_FAULT   = 0;
  localparam int ST_WRITE   = 1;
  localparam int ST_TIMEOUT = 2;

  // Saturation value of the fault counter
  localparam logic [15:0] FCOUNT_MAX = 16'hFFFF;

  // Transaction FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Debug view of the FSM, convenient to probe from checkers
  typedef struct packed {
    state_t      state;
    logic [15:0] timer;
  } dbg_t;

endpackage

// File: rtl/bus_guard_regs.sv
// Fault register file: sticky first-fault capture, saturating fault counter
// and the read mux for the memory-mapped window.
module bus_guard_regs
  import bus_guard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_fault_set,
  input  logic        i_fault_write,
  input  logic        i_fault_timeout,
  input  logic [31:0] i_fault_addr,
  input  logic        i_status_clr,
  input  logic [1:0]  i_rd_sel,
  output logic [31:0] o_rd_data,
  output logic        o_fault
);

  logic        r_fault;
  logic        r_fault_write;
  logic        r_fault_timeout;
  logic [31:0] r_fault_addr;
  logic [15:0] r_fault_count;

  // Sticky capture of the first fault; a new fault takes priority over a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault         <= 1'b0;
      r_fault_write   <= 1'b0;
      r_fault_timeout <= 1'b0;
      r_fault_addr    <= '0;
    end else if (i_fault_set) begin
      if (!r_fault) begin
        r_fault         <= 1'b1;
        r_fault_write   <= i_fault_write;
        r_fault_timeout <= i_fault_timeout;
        r_fault_addr    <= i_fault_addr;
      end
    end else if (i_status_clr) begin
      r_fault         <= 1'b0;
      r_fault_write   <= 1'b0;
      r_fault_timeout <= 1'b0;
    end
  end

  // Count every fault, saturating; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault_count <= '0;
    end else if (i_fault_set && (r_fault_count != FCOUNT_MAX)) begin
      r_fault_count <= r_fault_count + 16'd1;
    end
  end

  // Zero-extended read mux over the four window words
  always_comb begin
    o_rd_data = '0;
    case (i_rd_sel)
      REG_STATUS: begin
        o_rd_data[ST_FAULT]   = r_fault;
        o_rd_data[ST_WRITE]   = r_fault_write;
        o_rd_data[ST_TIMEOUT] = r_fault_timeout;
      end
      REG_FADDR:  o_rd_data = r_fault_addr;
      REG_FCOUNT: o_rd_data = {16'h0000, r_fault_count};
      default:    o_rd_data = '0;
    endcase
  end

  assign o_fault = r_fault;

endmodule

// File: rtl/bus_guard.sv
// Bus guard between the picorv32 memory port and the slave decode.
// Slave responses pass straight through; unmapped or stalled accesses are
// terminated with ERR_DATA and recorded in a small register window.
//
// Handshake: a request is pending while mem_valid = 1; it completes in the
// cycle mem_ready = 1. In pass-through, mem_ready is slv_ready combinationally.
// Locally terminated accesses complete one cycle after acceptance (RESP).
module bus_guard
  import bus_guard_pkg::*;
#(
  parameter logic [31:0] ADDR           = 32'h4000_7000,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        slv_sel,
  input  logic        slv_ready,
  input  logic [31:0] slv_rdata,
  output logic        fault_irq
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_timer;
  logic [15:0] w_timer_nxt;
  logic [31:0] r_resp_data;
  logic [31:0] w_resp_data_nxt;
  logic        w_resp_load;
  logic        w_fault_set;
  logic        w_fault_tmo;
  logic        w_status_clr;
  logic        w_own;
  logic        w_clr_req;
  logic        w_is_write;
  logic [31:0] w_reg_rdata;
  logic        w_fault;
  dbg_t        w_dbg;
  logic        w_unused;

  assign w_own      = (mem_addr[31:4] == ADDR[31:4]);
  assign w_is_write = |mem_wstrb;
  assign w_clr_req  = mem_wstrb[0] && mem_wdata[0] && (mem_addr[3:2] == REG_STATUS);

  // State, timer and the registered response word for RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_resp_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      if (w_resp_load) begin
        r_resp_data <= w_resp_data_nxt;
      end
    end
  end

  // Next state, fault events and CPU-facing outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = '0;
    w_resp_load     = 1'b0;
    w_resp_data_nxt = '0;
    w_fault_set     = 1'b0;
    w_fault_tmo     = 1'b0;
    w_status_clr    = 1'b0;
    mem_ready       = 1'b0;
    mem_rdata       = '0;
    unique case (r_state)
      S_IDLE: begin
        if (mem_valid) begin
          if (w_own) begin
            w_state_nxt     = S_RESP;
            w_resp_load     = 1'b1;
            w_resp_data_nxt = w_reg_rdata;
            w_status_clr    = w_clr_req;
          end else if (!slv_sel) begin
            w_state_nxt     = S_RESP;
            w_resp_load     = 1'b1;
            w_resp_data_nxt = ERR_DATA;
            w_fault_set     = 1'b1;
          end else begin
            mem_ready = slv_ready;
            mem_rdata = slv_rdata;
            if (!slv_ready) begin
              w_state_nxt = S_WAIT;
              w_timer_nxt = 16'd1;
            end
          end
        end
      end
      S_WAIT: begin
        if (!mem_valid) begin
          // CPU withdrew the request: drop it silently
          w_state_nxt = S_IDLE;
        end else begin
          mem_ready = slv_ready;
          mem_rdata = slv_rdata;
          if (slv_ready) begin
            w_state_nxt = S_IDLE;
          end else if (r_timer == TMO_LAST) begin
            w_state_nxt     = S_RESP;
            w_resp_load     = 1'b1;
            w_resp_data_nxt = ERR_DATA;
            w_fault_set     = 1'b1;
            w_fault_tmo     = 1'b1;
          end else begin
            w_timer_nxt = r_timer + 16'd1;
          end
        end
      end
      S_RESP: begin
        mem_ready   = 1'b1;
        mem_rdata   = r_resp_data;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Reset aborts any transfer in flight without completing it
    if (reset) begin
      mem_ready = 1'b0;
      mem_rdata = '0;
    end
  end

  bus_guard_regs u_regs (
    .clk             (clk),
    .reset           (reset),
    .i_fault_set     (w_fault_set),
    .i_fault_write   (w_is_write),
    .i_fault_timeout (w_fault_tmo),
    .i_fault_addr    (mem_addr),
    .i_status_clr    (w_status_clr),
    .i_rd_sel        (mem_addr[3:2]),
    .o_rd_data       (w_reg_rdata),
    .o_fault         (w_fault)
  );

  assign fault_irq = w_fault;

  assign w_dbg.state = r_state;
  assign w_dbg.timer = r_timer;

  // Only STATUS bit0 of the write data is meaningful
  assign w_unused = ^{mem_wdata[31:1], w_dbg};

endmodule

// File: tb/tb_bus_guard.sv
// Self-checking bench for bus_guard (TIMEOUT_CYCLES = 4).
module tb_bus_guard;
  import bus_guard_pkg::*;

  localparam logic [31:0] ADDR     = 32'h4000_7000;
  localparam int          TMO      = 4;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        slv_sel;
  logic        slv_ready;
  logic [31:0] slv_rdata;
  logic        fault_irq;

  // {check_data, data}
  logic [32:0] exp_q[$];

  int n_checks;
  int n_errors;

  // Bench model of the fault registers
  logic [31:0] m_status;
  logic [31:0] m_faddr;
  logic [15:0] m_fcount;

  int          r_delay;
  logic [31:0] r_val;

  bus_guard #(
    .ADDR           (ADDR),
    .TIMEOUT_CYCLES (TMO),
    .ERR_DATA       (ERR_DATA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .slv_sel   (slv_sel),
    .slv_ready (slv_ready),
    .slv_rdata (slv_rdata),
    .fault_irq (fault_irq)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic note_fault(input logic [31:0] addr, input logic wr, input logic tmo);
    if (!m_status[0]) begin
      m_status = {29'd0, tmo, wr, 1'b1};
      m_faddr  = addr;
    end
    if (m_fcount != 16'hFFFF) m_fcount = m_fcount + 16'd1;
  endtask

  // Drive one request and wait (bounded) for its completion.
  // rdy_at: cycle index (0 = request cycle) where slv_ready pulses, -1 = never.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic sel, input int rdy_at,
                        input logic [31:0] srdata, input logic [32:0] exp,
                        input int exp_lat);
    int          cyc;
    bit          done;
    logic [32:0] e;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    slv_sel   = sel;
    slv_rdata = srdata;
    slv_ready = (rdy_at == 0);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 16) begin
      @(negedge clk);
      if (mem_ready) begin
        e = exp_q.pop_front();
        check_eq("latency", 64'(cyc), 64'(exp_lat));
        if (e[32]) check_eq("rdata", {32'd0, mem_rdata}, {32'd0, e[31:0]});
        done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      slv_ready = (cyc == rdy_at);
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
    mem_wdata = '0;
    slv_sel   = 1'b0;
    slv_ready = 1'b0;
    slv_rdata = '0;
    check_eq("ready_seen", {63'd0, done}, 64'd1);
    if (!done) void'(exp_q.pop_front());
    @(negedge clk);
    check_eq("ready_once", {63'd0, mem_ready}, 64'd0);
  endtask

  task automatic slave_rd(input logic [31:0] addr, input int rdy_at, input logic [31:0] d);
    access(addr, 32'd0, 4'd0, 1'b1, rdy_at, d, {1'b1, d}, rdy_at);
  endtask

  task automatic slave_wr_hang(input logic [31:0] addr, input logic [31:0] wd);
    access(addr, wd, 4'hF, 1'b1, -1, 32'h0BAD_0BAD, {1'b1, ERR_DATA}, TMO);
    note_fault(addr, 1'b1, 1'b1);
  endtask

  task automatic unmapped(input logic [31:0] addr, input logic [3:0] wstrb);
    access(addr, 32'h1, wstrb, 1'b0, -1, 32'h0, {1'b1, ERR_DATA}, 1);
    note_fault(addr, |wstrb, 1'b0);
  endtask

  task automatic reg_rd(input logic [3:0] off, input logic [31:0] exp);
    access(ADDR + {28'd0, off}, 32'd0, 4'd0, 1'b0, -1, 32'h0, {1'b1, exp}, 1);
  endtask

  task automatic reg_wr(input logic [3:0] off, input logic [31:0] wd, input logic [3:0] wstrb);
    access(ADDR + {28'd0, off}, wd, wstrb, 1'b0, -1, 32'h0, 33'd0, 1);
    if (off == 4'h0 && wstrb[0] && wd[0]) m_status = '0;
  endtask

  task automatic chk_irq(input string tag);
    check_eq(tag, {63'd0, fault_irq}, {63'd0, m_status[0]});
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_status  = '0;
    m_faddr   = '0;
    m_fcount  = '0;
    reset     = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = 32'h1000_0000;
    mem_wdata = '0;
    mem_wstrb = '0;
    slv_sel   = 1'b1;
    slv_ready = 1'b1;
    slv_rdata = 32'hFFFF_FFFF;

    // Reset state: outputs held low even with a live slave response
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {63'd0, mem_ready}, 64'd0);
    check_eq("rst_rdata", {32'd0, mem_rdata}, 64'd0);
    check_eq("rst_irq", {63'd0, fault_irq}, 64'd0);
    check_eq("rst_state", {62'd0, dut.w_dbg.state}, {62'd0, S_IDLE});
    @(posedge clk); #1;
    mem_valid = 1'b0;
    slv_sel   = 1'b0;
    slv_ready = 1'b0;
    slv_rdata = '0;
    reset     = 1'b0;

    // Slave pass-through
    slave_rd(32'h1000_0000, 2, 32'h1234_5678);
    reg_rd(4'h0, 32'h0);
    slave_rd(32'h1000_0004, 0, 32'hCAFE_0001);
    for (int i = 0; i < 6; i++) begin
      r_delay = $urandom_range(0, 3);
      r_val   = $urandom;
      slave_rd(32'h1000_0010 + 32'(i * 4), r_delay, r_val);
    end

    // Slave answers on the very cycle the timer would expire
    slave_rd(32'h1000_0100, TMO - 1, 32'h5A5A_A5A5);
    reg_rd(4'h0, 32'h0);
    reg_rd(4'h8, 32'h0);

    // Unmapped read
    unmapped(32'h3000_0000, 4'h0);
    check_eq("irq_set", {63'd0, fault_irq}, 64'd1);
    reg_rd(4'h0, 32'h1);
    reg_rd(4'h4, 32'h3000_0000);
    reg_rd(4'h8, 32'h1);

    // Writes that must not clear STATUS
    reg_wr(4'h0, 32'h1, 4'b0010);
    reg_wr(4'h0, 32'h0, 4'b0001);
    reg_rd(4'h0, m_status);
    reg_wr(4'h0, 32'h1, 4'b0001);
    reg_rd(4'h0, 32'h0);
    chk_irq("irq_clr1");
    reg_rd(4'h8, 32'h1);

    // Write timeout, then a second fault while STATUS is held
    slave_wr_hang(32'h1000_0200, 32'hAAAA_5555);
    reg_rd(4'h0, 32'h7);
    reg_rd(4'h4, 32'h1000_0200);
    reg_rd(4'h8, 32'h2);
    unmapped(32'h3000_0010, 4'hF);
    reg_rd(4'h0, 32'h7);
    reg_rd(4'h4, 32'h1000_0200);
    reg_rd(4'h8, {16'd0, m_fcount});
    reg_wr(4'h0, 32'h1, 4'hF);
    reg_rd(4'h0, 32'h0);
    chk_irq("irq_clr2");
    reg_rd(4'h4, 32'h1000_0200);
    reg_rd(4'h8, 32'h3);

    // Reserved word
    reg_wr(4'hC, 32'hFFFF_FFFF, 4'hF);
    reg_rd(4'hC, 32'h0);

    // Counter saturation: preload near the top, then run past it
    @(negedge clk);
    force dut.u_regs.r_fault_count = 16'hFFFC;
    @(negedge clk);
    release dut.u_regs.r_fault_count;
    m_fcount = 16'hFFFC;
    for (int i = 0; i < 5; i++) begin
      unmapped(32'h2000_0000 + 32'(i * 4), 4'h0);
    end
    reg_rd(4'h8, 32'h0000_FFFF);
    reg_rd(4'h0, m_status);
    reg_rd(4'h4, 32'h2000_0000);
    chk_irq("irq_sat");

    // Reset in the middle of a stalled access
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = 32'h1000_0300;
    slv_sel   = 1'b1;
    slv_ready = 1'b0;
    slv_rdata = 32'h7777_7777;
    repeat (2) @(posedge clk);
    #1;
    check_eq("pre_rst_wait", {62'd0, dut.w_dbg.state}, {62'd0, S_WAIT});
    reset     = 1'b1;
    slv_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("midrst_ready", {63'd0, mem_ready}, 64'd0);
      @(posedge clk); #1;
    end
    reset     = 1'b0;
    mem_valid = 1'b0;
    slv_sel   = 1'b0;
    slv_ready = 1'b0;
    m_status  = '0;
    m_faddr   = '0;
    m_fcount  = '0;
    @(negedge clk);
    check_eq("post_rst_ready", {63'd0, mem_ready}, 64'd0);
    chk_irq("post_rst_irq");
    reg_rd(4'h0, 32'h0);
    reg_rd(4'h4, 32'h0);
    reg_rd(4'h8, 32'h0);

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_guard.md
Name: bus_guard

Overview:
- Sits between the picorv32 native memory port and the SoC slave address decode, one stage downstream of the CPU.
- Passes slave ready/rdata through with zero added latency.
- Terminates accesses that hit no slave, or that exceed a cycle budget, with an error word so the CPU never hangs.
- Records the first fault in a small memory-mapped register window; software reads and clears it.

Parameters:
- ADDR, 32'h4000_7000, base of the 16-byte register window (word-aligned, decoded on mem_addr[31:4]).
- TIMEOUT_CYCLES, 64, max cycles a mapped access may wait for slv_ready before fault; legal range 2..65535.
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on a faulted access.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  CPU request valid
- mem_addr  in  32  CPU address
- mem_wdata  in  32  CPU write data
- mem_wstrb  in  4  CPU byte strobes; 0 = read
- mem_ready  out  1  to CPU: transfer complete
- mem_rdata  out  32  to CPU: read data
- slv_sel  in  1  OR of all slave address-decode hits for the current mem_addr
- slv_ready  in  1  OR of all (sel && ready) terms from slaves
- slv_rdata  in  32  muxed slave read data
- fault_irq  out  1  level, high while STATUS.fault = 1

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state IDLE; STATUS, FAULT_ADDR, FAULT_COUNT and timer cleared.
  - Reset mid-transaction aborts it with no mem_ready.
- Register window at ADDR (own window; slv_sel must be 0 here):
  - +0x0 STATUS: bit0 fault (sticky), bit1 fault_was_write, bit2 fault_was_timeout (0 = unmapped). Write 1 to bit0 clears bits 0..2.
  - +0x4 FAULT_ADDR (RO): mem_addr of the first fault since last clear.
  - +0x8 FAULT_COUNT (RO): 16-bit count of all faults, saturates at 16'hFFFF, never cleared by STATUS write (reset only).
  - +0xC reads 0, writes ignored.
  - Reads zero-extend. Writes use mem_wdata bit0 only when mem_wstrb[0] = 1.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, mem_valid && own window -> RESP. Register read data is captured at the IDLE edge; mem_ready = 1 in RESP with that data (1-cycle latency).
  - IDLE, mem_valid && !slv_sel && !own -> RESP with fault: mem_rdata = ERR_DATA (also for writes), fault recorded (1-cycle latency).
  - IDLE, mem_valid && slv_sel: mem_ready = slv_ready and mem_rdata = slv_rdata, combinationally. If slv_ready, stay IDLE; else -> WAIT with timer = 1.
  - WAIT: mem_ready/mem_rdata pass-through.
    - slv_ready -> IDLE.
    - Else if timer == TIMEOUT_CYCLES-1 -> RESP with timeout fault.
    - Else timer++.
  - RESP: mem_ready = 1 for exactly one cycle, then IDLE. mem_ready is never 1 in consecutive cycles from RESP.
  - Back-to-back: a new request is accepted in IDLE on the cycle after any mem_ready.
- Outside IDLE/WAIT pass-through and RESP, mem_ready = 0 and mem_rdata = 0. slv_ready with mem_valid = 0 is ignored.
- Simultaneous events:
  - slv_ready in the same cycle the timer expires: slave wins, no fault.
  - Fault set and STATUS clear in the same cycle: set wins.
  - A second fault while STATUS.fault = 1: FAULT_ADDR and flags are unchanged; FAULT_COUNT still increments.
- mem_valid dropping while in WAIT (protocol violation): return to IDLE, no fault, no ready.
- Timer is 16-bit and is reloaded at the start of every transaction.

Decomposition:
- Shared package/header (bus_guard_defs):
  - register offset constants REG_STATUS/REG_FADDR/REG_FCOUNT;
  - STATUS bit indices;
  - state encoding localparams.
- One natural sub-module: bus_guard_regs, holding the register file, sticky capture, saturating counter and read mux.
- FSM and timer stay in the top.

Test Plan:
- Read of a mapped slave with slv_ready asserted on cycle 3 (slv_rdata = 32'h1234_5678) -> mem_ready high on cycle 3 only, mem_rdata = 32'h1234_5678, STATUS = 0.
- Read of 32'h3000_0000 with slv_sel = 0 -> mem_ready on the next cycle, mem_rdata = 32'hDEAD_BEEF, STATUS = 32'h1, FAULT_ADDR = 32'h3000_0000, FAULT_COUNT = 1, fault_irq = 1.
- Write to a mapped slave that never readies, TIMEOUT_CYCLES = 4 -> mem_ready exactly 4 cycles after mem_valid, STATUS = 32'h7.
- slv_ready arriving on the same cycle as timer expiry -> slave data returned, STATUS stays 0, FAULT_COUNT unchanged.
- Two faults, then write 1 to STATUS (ADDR+0) -> STATUS = 0, fault_irq = 0, FAULT_ADDR holds the first fault address, FAULT_COUNT = 2.
- 70000 forced faults -> FAULT_COUNT = 16'hFFFF. Assert reset mid-WAIT -> mem_ready stays 0 and all registers read 0 afterwards.
